// File: rtl/psec6_readout_pkg.sv
// Shared types and frame constants for the per-channel readout path.
package psec6_readout_pkg;

    localparam int unsigned NSLOT = 5;
    localparam int unsigned CW    = 10;
    localparam int unsigned TCW   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FULL,
        ST_FREEZE,
        ST_PULSE
    } cap_state_e;

endpackage

// File: rtl/ch_trigger_capture_if.sv
// Trigger-recorder bundle between channel control (master) and the recorder (slave).
interface ch_trigger_capture_if;
    import psec6_readout_pkg::*;

    logic           TRIG;
    logic           ARM;
    logic           READ_REQ;
    logic [TCW-1:0] trigger_cnt;
    logic [CW-1:0]  CA;
    logic [CW-1:0]  CB;
    logic [CW-1:0]  CC;
    logic [CW-1:0]  CD;
    logic [CW-1:0]  CE;
    logic           INST_READOUT;
    logic           BUSY;
    logic           OVF;

    modport master (
        output TRIG, ARM, READ_REQ,
        input  trigger_cnt, CA, CB, CC, CD, CE, INST_READOUT, BUSY, OVF
    );

    modport slave (
        input  TRIG, ARM, READ_REQ,
        output trigger_cnt, CA, CB, CC, CD, CE, INST_READOUT, BUSY, OVF
    );

endinterface

// File: rtl/trig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-cycle rising-edge pulse.
module trig_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RSTB,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              sync_d;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            sync_d <= sync_q[STAGES-1];
        end
    end

    assign pulse = sync_q[STAGES-1] & ~sync_d;

endmodule

// File: rtl/ch_trigger_capture.sv
// Per-channel trigger recorder: stamps up to NSLOT trigger edges with a coarse counter,
// then freezes the record and strobes INST_READOUT so the serializer latches it.
module ch_trigger_capture
    import psec6_readout_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 2
) (
    input  logic CLK,
    input  logic RSTB,
    ch_trigger_capture_if.slave bus
);

    localparam int unsigned PCW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    cap_state_e     state;
    logic [CW-1:0]  coarse;
    logic [CW-1:0]  slot [NSLOT];
    logic [TCW-1:0] trigger_cnt;
    logic [PCW-1:0] pcnt;
    logic           inst_readout;
    logic           busy;
    logic           ovf;
    logic           trg_evt;

    trig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .async_in (bus.TRIG),
        .pulse    (trg_evt)
    );

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state        <= ST_IDLE;
            coarse       <= '0;
            trigger_cnt  <= '0;
            pcnt         <= '0;
            inst_readout <= 1'b0;
            busy         <= 1'b0;
            ovf          <= 1'b0;
            for (int unsigned i = 0; i < NSLOT; i++) slot[i] <= '0;
        end else if (bus.ARM && (state inside {ST_IDLE, ST_ARMED, ST_FULL})) begin
            // ARM wins over a same-cycle trigger or read request
            state       <= ST_ARMED;
            coarse      <= '0;
            trigger_cnt <= '0;
            ovf         <= 1'b0;
            for (int unsigned i = 0; i < NSLOT; i++) slot[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_ARMED, ST_FULL: begin
                    coarse <= coarse + CW'(1);
                    if (trg_evt) begin
                        if (state == ST_ARMED) begin
                            for (int unsigned i = 0; i < NSLOT; i++)
                                if (trigger_cnt == TCW'(i)) slot[i] <= coarse;
                            trigger_cnt <= trigger_cnt + TCW'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                    // a trigger in the request cycle is captured above before freezing
                    if (bus.READ_REQ) begin
                        state <= ST_FREEZE;
                        busy  <= 1'b1;
                    end else if (state == ST_ARMED && trg_evt &&
                                 trigger_cnt == TCW'(NSLOT - 1)) begin
                        state <= ST_FULL;
                    end
                end
                ST_FREEZE: begin
                    state        <= ST_PULSE;
                    inst_readout <= 1'b1;
                    pcnt         <= '0;
                end
                ST_PULSE: begin
                    if (pcnt == PCW'(PULSE_LEN - 1)) begin
                        state        <= ST_IDLE;
                        inst_readout <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        pcnt <= pcnt + PCW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.trigger_cnt  = trigger_cnt;
    assign bus.CA           = slot[0];
    assign bus.CB           = slot[1];
    assign bus.CC           = slot[2];
    assign bus.CD           = slot[3];
    assign bus.CE           = slot[4];
    assign bus.INST_READOUT = inst_readout;
    assign bus.BUSY         = busy;
    assign bus.OVF          = ovf;

endmodule
